// File: rtl/mem_stage_if.sv
// Execute -> memory -> write-back handshake bundle for the memory-access stage.
// master: execute/cache/write-back side, slave: mem_stage.
`timescale 1ns/1ps
interface mem_stage_if;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_load_op;
  logic        es_store_op;
  logic [1:0]  es_mem_size;
  logic        es_mem_sign_exted;
  logic        es_req_issued;
  logic        es_excp;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        excp_flush;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_excp;
  logic        ms_flush;
  logic        ms_fwd_en;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_stall;

  modport master (
    output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op,
           es_store_op, es_mem_size, es_mem_sign_exted, es_req_issued, es_excp,
           data_data_ok, data_rdata, excp_flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest,
           ms_gr_we, ms_excp, ms_flush, ms_fwd_en, ms_fwd_dest, ms_fwd_data,
           ms_fwd_stall
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op,
           es_store_op, es_mem_size, es_mem_sign_exted, es_req_issued, es_excp,
           data_data_ok, data_rdata, excp_flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest,
           ms_gr_we, ms_excp, ms_flush, ms_fwd_en, ms_fwd_dest, ms_fwd_data,
           ms_fwd_stall
  );
endinterface

// File: rtl/mem_stage.sv
// LoongArch memory-access stage: waits for the data-cache response, aligns/extends loads.
// Optional macro MEM_LOAD_FWD_EN: bypass returning load data to decode in the response cycle.
`timescale 1ns/1ps
module mem_stage (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);
  logic        ms_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_result;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_load_op;
  logic        ms_store_op;
  logic [1:0]  ms_mem_size;
  logic        ms_mem_sign_exted;
  logic        ms_req_issued;
  logic        ms_excp;

  logic        buf_valid;
  logic [31:0] rdata_buf;
  logic        discard;

  logic        need_data;
  logic        data_data_ok_live;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic        ms_leave;
  logic [31:0] load_word;
  logic [31:0] ms_final_result;

  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  addr,
                                             input logic [1:0]  size,
                                             input logic        sign_ext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    if (size[0])
      return sign_ext ? 32'(b) : {24'd0, b};
    else if (size[1])
      return sign_ext ? 32'(h) : {16'd0, h};
    return word;
  endfunction

  // A cache request only exists for memory operations that execute got accepted.
  assign need_data         = ms_valid & ms_req_issued & ~ms_excp & (ms_load_op | ms_store_op);
  assign data_data_ok_live = bus.data_data_ok & ~discard;
  assign ms_ready_go       = ~need_data | data_data_ok_live | buf_valid;
  assign ms_allowin        = ~ms_valid | (ms_ready_go & bus.ws_allowin);
  assign ms_to_ws_valid    = ms_valid & ms_ready_go;
  assign ms_leave          = ms_to_ws_valid & bus.ws_allowin;

  assign load_word       = buf_valid ? rdata_buf : bus.data_rdata;
  assign ms_final_result = ms_load_op
                           ? align_load(load_word, ms_result[1:0], ms_mem_size, ms_mem_sign_exted)
                           : ms_result;

  assign bus.ms_allowin      = ms_allowin;
  assign bus.ms_to_ws_valid  = ms_to_ws_valid;
  assign bus.ms_pc           = ms_pc;
  assign bus.ms_final_result = ms_final_result;
  assign bus.ms_dest         = ms_dest;
  assign bus.ms_gr_we        = ms_gr_we;
  assign bus.ms_excp         = ms_excp;
  assign bus.ms_flush        = ms_valid & ms_excp;
  assign bus.ms_fwd_en       = ms_valid & ms_gr_we & (ms_dest != 5'd0);
  assign bus.ms_fwd_dest     = ms_dest;
  assign bus.ms_fwd_data     = ms_final_result;
`ifdef MEM_LOAD_FWD_EN
  assign bus.ms_fwd_stall    = ms_valid & ms_load_op & need_data & ~data_data_ok_live & ~buf_valid;
`else
  assign bus.ms_fwd_stall    = ms_valid & ms_load_op & ~ms_excp;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid          <= 1'b0;
      ms_pc             <= 32'd0;
      ms_result         <= 32'd0;
      ms_dest           <= 5'd0;
      ms_gr_we          <= 1'b0;
      ms_load_op        <= 1'b0;
      ms_store_op       <= 1'b0;
      ms_mem_size       <= 2'd0;
      ms_mem_sign_exted <= 1'b0;
      ms_req_issued     <= 1'b0;
      ms_excp           <= 1'b0;
      buf_valid         <= 1'b0;
      rdata_buf         <= 32'd0;
      discard           <= 1'b0;
    end else begin
      if (bus.excp_flush)
        ms_valid <= 1'b0;
      else if (ms_allowin)
        ms_valid <= bus.es_to_ms_valid;

      if (bus.es_to_ms_valid & ms_allowin) begin
        ms_pc             <= bus.es_pc;
        ms_result         <= bus.es_result;
        ms_dest           <= bus.es_dest;
        ms_gr_we          <= bus.es_gr_we;
        ms_load_op        <= bus.es_load_op;
        ms_store_op       <= bus.es_store_op;
        ms_mem_size       <= bus.es_mem_size;
        ms_mem_sign_exted <= bus.es_mem_sign_exted;
        ms_req_issued     <= bus.es_req_issued;
        ms_excp           <= bus.es_excp;
      end

      // Hold a response that write-back cannot take yet.
      if (bus.excp_flush | ms_leave)
        buf_valid <= 1'b0;
      else if (need_data & data_data_ok_live & ~bus.ws_allowin) begin
        buf_valid <= 1'b1;
        rdata_buf <= bus.data_rdata;
      end

      // A flushed request still gets answered by the cache; swallow that answer.
      if (bus.excp_flush & need_data & ~data_data_ok_live & ~buf_valid)
        discard <= 1'b1;
      else if (bus.data_data_ok)
        discard <= 1'b0;
    end
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, sitting between the execute stage and write-back. It accepts one instruction per handshake from execute and waits for the data-cache response of any load or store that execute issued. It aligns and extends load data, forwards its result to decode for bypassing, and discards late cache responses that belong to flushed instructions.

## Interface
- Parameters: none; all widths fixed.
- `clk` in 1 — pipeline clock.
- `reset` in 1 — asynchronous, active-high.
- `es_to_ms_valid` in 1 — execute offers an instruction.
- `ms_allowin` out 1 — stage can accept this cycle.
- `es_pc` in 32 — instruction PC.
- `es_result` in 32 — ALU/CSR result; for memory operations, the byte address.
- `es_dest` in 5 — destination GPR.
- `es_gr_we` in 1 — GPR write enable.
- `es_load_op` / `es_store_op` in 1 each — memory operation type.
- `es_mem_size` in 2 — bit0 = byte, bit1 = half, 00 = word.
- `es_mem_sign_exted` in 1 — 1 = sign-extend load, 0 = zero-extend.
- `es_req_issued` in 1 — execute's cache request was accepted (addr_ok).
- `es_excp` in 1 — instruction carries an exception.
- `data_data_ok` in 1 — cache response strobe.
- `data_rdata` in 32 — cache read data, word-aligned.
- `excp_flush` in 1 — pipeline flush from write-back.
- `ws_allowin` in 1 — write-back can accept.
- `ms_to_ws_valid` out 1 — result valid to write-back.
- `ms_pc` out 32, `ms_final_result` out 32, `ms_dest` out 5, `ms_gr_we` out 1, `ms_excp` out 1 — registered or derived state sent to write-back.
- `ms_flush` out 1 — `ms_valid & ms_excp`; execute suppresses new requests while high.
- `ms_fwd_en` out 1, `ms_fwd_dest` out 5, `ms_fwd_data` out 32, `ms_fwd_stall` out 1 — bypass path to decode.

## Operation
- Capture: on `es_to_ms_valid & ms_allowin`, all `es_*` inputs are registered and `ms_valid <= 1`. On `ms_allowin` with no offer, `ms_valid <= 0`.
- `need_data = ms_valid & ms_req_issued & ~ms_excp`.
- `ms_ready_go = ~need_data | data_data_ok_live | buf_valid`, where `data_data_ok_live = data_data_ok & ~discard`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go`.
- Response buffer: if `need_data & data_data_ok_live & ~ws_allowin`, latch `data_rdata` into `rdata_buf` and set `buf_valid`. `buf_valid` clears when the instruction leaves the stage or is flushed.
- Load data source: `buf_valid ? rdata_buf : data_rdata`.
- Byte select by `addr[1:0]`, halfword by `addr[1]`, word passes through. Extension follows `ms_mem_sign_exted`.
- `ms_final_result`: aligned load data for loads, otherwise `ms_result`. Stores forward `ms_result` (irrelevant when `ms_gr_we = 0`).
- Flush: `excp_flush` clears `ms_valid` and `buf_valid` on the next edge. If `need_data` is set and no live `data_data_ok` arrives in that cycle, set `discard`. The next `data_data_ok` is consumed silently and clears `discard`.
- Only one cache response can be outstanding per stage. `discard` and a new `need_data` cannot coexist, because execute is held off by the flush.
- Forwarding:
  - `ms_fwd_en = ms_valid & ms_gr_we & (ms_dest != 0)`.
  - `ms_fwd_dest = ms_dest`.
  - `ms_fwd_data = ms_final_result`.
  - `ms_fwd_stall`: see Configuration.

## Timing
- Reset: `ms_valid`, `buf_valid`, `discard` = 0. All registered payload = 0. `ms_to_ws_valid`, `ms_flush`, `ms_fwd_en`, `ms_fwd_stall` = 0. `ms_allowin` = 1.
- Non-memory instructions and exceptions: 1 cycle in stage when `ws_allowin = 1`.
- Loads and stores: exit in the cycle `data_data_ok` arrives (earliest: the cycle after capture), or the first cycle `ws_allowin` is high after buffering.
- Simultaneous `excp_flush` and live `data_data_ok`: the response is dropped, `discard` stays 0, and `ms_valid` clears.
- Simultaneous flush and capture: flush wins, so `ms_valid <= 0`.
- Reset mid-wait clears `discard`. The cache controller is reset by the same signal, so no stale response arrives.

## Configuration
- `MEM_LOAD_FWD_EN` defined: `ms_fwd_stall = ms_valid & ms_load_op & need_data & ~data_data_ok_live & ~buf_valid`. Load data is bypassed to decode in the same cycle it returns.
- Not defined: `ms_fwd_stall = ms_valid & ms_load_op & ~ms_excp`. Decode waits for the load to reach write-back.

## Test plan
- Word load: addr 0x1000, response 0xDEADBEEF one cycle after capture, `ws_allowin = 1` → `ms_to_ws_valid` that cycle, `ms_final_result = 0xDEADBEEF`.
- `ld.b` sign-extended at addr 0x1003, rdata 0x80112233 → result 0xFFFFFF80. `ld.hu` at addr 0x1002, same rdata → result 0x00008011.
- Response while `ws_allowin = 0` for 3 cycles → `buf_valid = 1`, `ms_allowin = 0`; when `ws_allowin` rises, result equals the buffered data and `buf_valid` clears.
- Flush while a load awaits data, response arriving 2 cycles later → `ms_valid = 0`, `discard = 1`, the response is ignored, and the following load returns its own data correctly.
- Instruction with `es_excp = 1` and `es_req_issued = 0` → `ms_flush = 1`, exits in 1 cycle without waiting for data.
- `MEM_LOAD_FWD_EN` on vs off, load to r5 → `ms_fwd_stall` drops in the `data_data_ok` cycle when on; it stays 1 while the load is in the stage when off.
